delay_burst_slave: RTL
======================

Name: delay_burst_slave

Overview:
- Generic responder for the controller's master port: single-ID burst read and burst write channels backed by a 256x8 register memory.
- Per-transaction access latency is set at run time by the DELAY input, so one block can stand in for the ALU, memory or I/O slave.
- Exposes idle/previous-idle status so the controller can detect transaction completion edges.

Parameters:
- INIT_XOR, 8'h00: at reset, mem[i] = i ^ INIT_XOR.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- ARVALID  in  1  read request valid
- ARREADY  out  1  read request accepted
- IN  in  16  read request: [15:12] ignored, [11:4] start address, [3:0] beats-1
- RVALID  out  1  read beat valid
- RREADY  in  1  read beat taken
- RLAST  out  1  final read beat
- OUT  out  9  read beat: [7:0] data, [8] wrap flag
- AWVALID  in  1  write request valid
- AWREADY  out  1  write request accepted
- AWIN  in  12  write request: [11:4] start address, [3:0] beats-1
- WVALID  in  1  write beat valid
- WREADY  out  1  write beat accepted
- WDATA  in  8  write beat data
- WLAST  in  1  master's final write beat
- BVALID  out  1  write response valid
- BREADY  in  1  write response taken
- BRESP  out  5  number of beats written, 1..16
- DELAY  in  5  latency in cycles, sampled at request acceptance
- RIDLE, WIDLE  out  1  read/write FSM in idle state
- RIDLE_prev, WIDLE_prev  out  1  RIDLE/WIDLE registered one cycle earlier

Behaviour:
- Reset (async): read FSM to R_IDLE, write FSM to W_IDLE.
- Reset output values: ARREADY=1, AWREADY=1, RIDLE=WIDLE=1, RIDLE_prev=WIDLE_prev=1. All other outputs 0.
- Reset reloads all memory locations. Any in-flight burst is abandoned with no response.
- Read FSM:
  - R_IDLE: ARREADY=1. On ARVALID, latch addr=IN[11:4], len=IN[3:0], and cnt=DELAY. Go to R_WAIT, or directly to R_BURST if DELAY=0.
  - R_WAIT: cnt decrements each cycle. When cnt reaches 1, go to R_BURST next cycle. A DELAY of N gives N idle cycles between acceptance and the first RVALID.
  - R_BURST: RVALID=1. OUT[7:0]=mem[addr+beat] (8-bit wrap). OUT[8]=1 when the beat address has wrapped past 8'hFF. RLAST=1 on beat number len.
  - OUT and RLAST are registered and hold stable while RVALID && !RREADY.
  - On RVALID && RREADY: advance one beat. After the last beat, return to R_IDLE with RVALID=0 in the following cycle.
- Write FSM:
  - W_IDLE: AWREADY=1. On AWVALID, latch addr, len and DELAY. Go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID beat writes mem[addr+n] at the clock edge and increments the beat count.
  - W_DATA exits on WLAST, or after len+1 beats even if WLAST is missing. Beats beyond len+1 are not accepted because WREADY drops.
  - An early WLAST truncates the burst. BRESP reports the beats actually written.
  - W_WAIT: counts DELAY cycles, skipped if DELAY=0.
  - W_RESP: BVALID=1 with BRESP held stable until BREADY, then return to W_IDLE.
- The read and write FSMs are independent and may run concurrently.
- Collision ordering: a read beat loaded in the same cycle as a write to the same address returns the old data. A write committed on an earlier edge is visible.
- ARREADY and AWREADY are 0 outside their idle states, so there is no request queuing.
- DELAY changes after acceptance have no effect on the transaction in flight.
- *_prev outputs are plain registers of RIDLE/WIDLE. A 1->0 transition marks a start and a 0->1 transition marks completion.

Test Plan:
- Reset then read addr 8'h10, len 3, DELAY=0, RREADY=1 -> first RVALID 1 cycle after accept; OUT=0x010,0x011,0x012,0x013; RLAST on the 4th beat only.
- Write addr 8'h20, 2 beats (AA, BB) with WLAST on beat 2, DELAY=5, BREADY=1 -> BVALID 5 cycles after the last beat; BRESP=2. A subsequent read of 8'h20 len 1 returns AA, BB.
- Read addr 8'hFE, len 3 with RREADY toggled 1,0,0,1... -> data FE, FF, 00, 01; OUT[8]=0,0,1,1; OUT held stable during stalls.
- Write len 7 with WLAST on beat 3 -> WREADY drops after beat 3; BRESP=3; mem at the 4th address unchanged.
- Concurrent read (DELAY 10) and write to overlapping addresses -> both complete. RIDLE_prev/WIDLE_prev lag RIDLE/WIDLE by exactly 1 cycle.
- Assert rst mid-read-burst and mid-write-wait -> outputs return to reset values immediately; memory reinitialised; next request is accepted normally.

Source files
------------

// File: rtl/delay_burst_slave_if.sv
// Burst read/write bus between the controller (master) and a slave.
interface delay_burst_slave_if;
  logic        ARVALID;
  logic        ARREADY;
  logic [15:0] IN;
  logic        RVALID;
  logic        RREADY;
  logic        RLAST;
  logic [8:0]  OUT;
  logic        AWVALID;
  logic        AWREADY;
  logic [11:0] AWIN;
  logic        WVALID;
  logic        WREADY;
  logic [7:0]  WDATA;
  logic        WLAST;
  logic        BVALID;
  logic        BREADY;
  logic [4:0]  BRESP;

  modport slave (
    input  ARVALID, IN, RREADY, AWVALID, AWIN, WVALID, WDATA, WLAST, BREADY,
    output ARREADY, RVALID, RLAST, OUT, AWREADY, WREADY, BVALID, BRESP
  );

  modport master (
    output ARVALID, IN, RREADY, AWVALID, AWIN, WVALID, WDATA, WLAST, BREADY,
    input  ARREADY, RVALID, RLAST, OUT, AWREADY, WREADY, BVALID, BRESP
  );
endinterface

// File: rtl/delay_burst_slave.sv
// Generic burst slave: 256x8 register memory behind independent read and
// write FSMs, with a per-transaction latency taken from DELAY at acceptance.
//
// state   | meaning
// R_IDLE  | ARREADY high, waiting for a read request
// R_WAIT  | counting down the read latency
// R_BURST | RVALID high, presenting beats until the last one is taken
// W_IDLE  | AWREADY high, waiting for a write request
// W_DATA  | WREADY high, committing write beats
// W_WAIT  | counting down the write response latency
// W_RESP  | BVALID high until BREADY
module delay_burst_slave #(
  parameter logic [7:0] INIT_XOR = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  delay_burst_slave_if.slave   bus,
  input  logic [4:0]           DELAY,
  output logic                 RIDLE,
  output logic                 WIDLE,
  output logic                 RIDLE_prev,
  output logic                 WIDLE_prev
);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;

  logic [7:0] mem [256];

  r_state_t   r_state;
  logic [7:0] r_addr;
  logic [3:0] r_len;
  logic [4:0] r_cnt;
  logic [3:0] r_beat;
  logic [3:0] r_beat_nxt;
  logic [8:0] r_sum_nxt;

  w_state_t   w_state;
  logic [7:0] w_addr;
  logic [3:0] w_len;
  logic [4:0] w_dly;
  logic [4:0] w_cnt;
  logic [4:0] w_wait;
  logic [4:0] w_beats;
  logic       w_done;
  logic       wr_en;
  logic [7:0] wr_addr;

  // Request bits [15:12] carry no meaning for this slave.
  logic unused_in;
  assign unused_in = ^bus.IN[15:12];

  // The 9-bit sum exposes the carry out of the 8-bit address as the wrap flag.
  assign r_beat_nxt = r_beat + 4'd1;
  assign r_sum_nxt  = {1'b0, r_addr} + {5'd0, r_beat_nxt};

  assign wr_en   = (w_state == W_DATA) && bus.WVALID && bus.WREADY;
  assign wr_addr = w_addr + {3'd0, w_cnt};
  assign w_done  = bus.WLAST || (w_cnt[3:0] == w_len);
  assign w_beats = w_cnt + 5'd1;

  // Register memory; reset reloads the initial pattern. A read beat loaded on
  // the same edge as a write naturally sees the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ INIT_XOR;
    end else if (wr_en) begin
      mem[wr_addr] <= bus.WDATA;
    end
  end

  // Read FSM with registered handshake, data and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= R_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_beat      <= '0;
      bus.ARREADY <= 1'b1;
      bus.RVALID  <= 1'b0;
      bus.RLAST   <= 1'b0;
      bus.OUT     <= '0;
      RIDLE       <= 1'b1;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (bus.ARVALID) begin
            r_addr      <= bus.IN[11:4];
            r_len       <= bus.IN[3:0];
            r_cnt       <= DELAY;
            r_beat      <= '0;
            bus.ARREADY <= 1'b0;
            RIDLE       <= 1'b0;
            if (DELAY == 5'd0) begin
              r_state    <= R_BURST;
              bus.RVALID <= 1'b1;
              bus.OUT    <= {1'b0, mem[bus.IN[11:4]]};
              bus.RLAST  <= (bus.IN[3:0] == 4'd0);
            end else begin
              r_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_state    <= R_BURST;
            bus.RVALID <= 1'b1;
            bus.OUT    <= {1'b0, mem[r_addr]};
            bus.RLAST  <= (r_len == 4'd0);
          end
        end
        R_BURST: begin
          if (bus.RREADY) begin
            if (r_beat == r_len) begin
              r_state     <= R_IDLE;
              bus.RVALID  <= 1'b0;
              bus.RLAST   <= 1'b0;
              bus.ARREADY <= 1'b1;
              RIDLE       <= 1'b1;
            end else begin
              r_beat    <= r_beat_nxt;
              bus.OUT   <= {r_sum_nxt[8], mem[r_sum_nxt[7:0]]};
              bus.RLAST <= (r_beat_nxt == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM: data phase ends on WLAST or a full burst, whichever comes first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state     <= W_IDLE;
      w_addr      <= '0;
      w_len       <= '0;
      w_dly       <= '0;
      w_cnt       <= '0;
      w_wait      <= '0;
      bus.AWREADY <= 1'b1;
      bus.WREADY  <= 1'b0;
      bus.BVALID  <= 1'b0;
      bus.BRESP   <= '0;
      WIDLE       <= 1'b1;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (bus.AWVALID) begin
            w_addr      <= bus.AWIN[11:4];
            w_len       <= bus.AWIN[3:0];
            w_dly       <= DELAY;
            w_cnt       <= '0;
            bus.AWREADY <= 1'b0;
            bus.WREADY  <= 1'b1;
            WIDLE       <= 1'b0;
            w_state     <= W_DATA;
          end
        end
        W_DATA: begin
          if (wr_en) begin
            w_cnt <= w_beats;
            if (w_done) begin
              bus.WREADY <= 1'b0;
              if (w_dly == 5'd0) begin
                w_state    <= W_RESP;
                bus.BVALID <= 1'b1;
                bus.BRESP  <= w_beats;
              end else begin
                w_state <= W_WAIT;
                w_wait  <= w_dly;
              end
            end
          end
        end
        W_WAIT: begin
          w_wait <= w_wait - 5'd1;
          if (w_wait == 5'd1) begin
            w_state    <= W_RESP;
            bus.BVALID <= 1'b1;
            bus.BRESP  <= w_cnt;
          end
        end
        W_RESP: begin
          if (bus.BREADY) begin
            bus.BVALID  <= 1'b0;
            bus.AWREADY <= 1'b1;
            WIDLE       <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // One-cycle-delayed idle flags for start/completion edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RIDLE_prev <= 1'b1;
      WIDLE_prev <= 1'b1;
    end else begin
      RIDLE_prev <= RIDLE;
      WIDLE_prev <= WIDLE;
    end
  end

endmodule
